// File: rtl/alarm_led_blinker_pkg.sv
// Shared definitions for the alarm LED blinker.
// Holds the register map offsets, the CTRL and STATUS bit positions and
// the run-state encoding used by alarm_led_blinker.
package alarm_led_blinker_pkg;

  // Register offsets on the 2-bit Avalon address
  localparam logic [1:0] REG_CTRL   = 2'd0;
  localparam logic [1:0] REG_PERIOD = 2'd1;
  localparam logic [1:0] REG_COUNT  = 2'd2;
  localparam logic [1:0] REG_STATUS = 2'd3;

  // CTRL bit indices
  localparam int CTRL_START  = 0;
  localparam int CTRL_STOP   = 1;
  localparam int CTRL_MANUAL = 2;
  localparam int CTRL_IRQ_EN = 3;

  // STATUS bit indices; the remaining-blink count starts at ST_REM_LSB
  localparam int ST_BUSY    = 0;
  localparam int ST_DONE    = 1;
  localparam int ST_OUT     = 2;
  localparam int ST_REM_LSB = 16;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ON   = 2'd1,
    S_OFF  = 2'd2
  } state_e;

endpackage

// File: rtl/alarm_tick_gen.sv
// Free-running prescaler that produces a one-cycle tick every PRESCALE
// clock cycles. A synchronous clear restarts the count from zero so that
// the first tick after a clear comes exactly PRESCALE cycles later.
//
// Ports:
//   clk     in  system clock
//   reset_n in  asynchronous active-low reset
//   clr     in  synchronous clear of the prescaler
//   tick    out high in the cycle where the prescaler holds PRESCALE-1
module alarm_tick_gen #(
  parameter int PRESCALE = 50000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clr,
  output logic tick
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

  logic [PW-1:0] cnt;

  assign tick = (cnt == LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (clr || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/alarm_led_blinker.sv
// Avalon-MM slave that drives the alarm LED pin. While idle the pin follows
// a CPU-written manual level; a blink run (started by CPU or by a rising
// edge on alarm_trig) toggles the pin with a programmable half-period for a
// programmable number of blinks (or until stopped) and flags done/irq.
//
// Ports:
//   clk        in   system clock
//   reset_n    in   asynchronous active-low reset
//   address    in   register select: 0 CTRL, 1 PERIOD, 2 COUNT, 3 STATUS
//   chipselect in   slave select
//   write_n    in   active-low write strobe
//   writedata  in   write data (bits above register width ignored)
//   readdata   out  combinational read mux, zero wait states
//   alarm_trig in   rising edge starts a blink run
//   out_port   out  registered LED drive
//   irq        out  level interrupt, done & irq_en
module alarm_led_blinker
  import alarm_led_blinker_pkg::*;
#(
  parameter int PRESCALE = 50000,
  parameter int CNT_W    = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  input  logic        alarm_trig,
  output logic        out_port,
  output logic        irq
);

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  state_e           state;
  logic [CNT_W-1:0] period_r;
  logic [CNT_W-1:0] count_r;
  logic             manual;
  logic             irq_en;
  logic             done;
  logic             trig_q;
  logic [CNT_W-1:0] phase_cnt;
  logic [CNT_W-1:0] phase_len;
  logic [CNT_W-1:0] remaining;

  logic             wr_en;
  logic             ctrl_wr;
  logic             period_wr;
  logic             count_wr;
  logic             status_wr;
  logic             start_req;
  logic             stop_req;
  logic             manual_nxt;
  logic [CNT_W-1:0] period_eff;
  logic             tick;
  logic             tick_clr;
  logic             phase_end;
  logic             done_set;
  logic             unused_wd;

  assign wr_en     = chipselect && !write_n;
  assign ctrl_wr   = wr_en && (address == REG_CTRL);
  assign period_wr = wr_en && (address == REG_PERIOD);
  assign count_wr  = wr_en && (address == REG_COUNT);
  assign status_wr = wr_en && (address == REG_STATUS);

  assign start_req = (ctrl_wr && writedata[CTRL_START]) || (alarm_trig && !trig_q);
  assign stop_req  = ctrl_wr && writedata[CTRL_STOP];

  // Idle level follows a MANUAL write in the same cycle it is written
  assign manual_nxt = ctrl_wr ? writedata[CTRL_MANUAL] : manual;

  assign period_eff = (period_r == '0) ? ONE : period_r;

  // Keep the prescaler parked while idle so every phase starts aligned
  assign tick_clr  = start_req || stop_req || (state == S_IDLE);
  assign phase_end = tick && (phase_cnt == (phase_len - ONE));

  assign done_set = (state == S_OFF) && phase_end && (remaining == ONE) &&
                    !start_req && !stop_req;

  assign irq       = done && irq_en;
  assign unused_wd = ^writedata[31:CNT_W];

  alarm_tick_gen #(
    .PRESCALE(PRESCALE)
  ) u_tick (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (tick_clr),
    .tick    (tick)
  );

  // Register file and trigger edge register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      period_r <= '0;
      count_r  <= '0;
      manual   <= 1'b0;
      irq_en   <= 1'b0;
      done     <= 1'b0;
      trig_q   <= 1'b0;
    end else begin
      trig_q <= alarm_trig;
      if (ctrl_wr) begin
        manual <= writedata[CTRL_MANUAL];
        irq_en <= writedata[CTRL_IRQ_EN];
      end
      if (period_wr) period_r <= writedata[CNT_W-1:0];
      if (count_wr)  count_r  <= writedata[CNT_W-1:0];
      // A completion in the same cycle as a W1C clear keeps done set
      if (done_set) begin
        done <= 1'b1;
      end else if (status_wr && writedata[ST_DONE]) begin
        done <= 1'b0;
      end
    end
  end

  // Blink FSM; out_port is registered from the state being entered.
  // PERIOD is latched into phase_len at each phase start, COUNT only at run start.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      out_port  <= 1'b0;
      phase_cnt <= '0;
      phase_len <= '0;
      remaining <= '0;
    end else if (stop_req) begin
      state     <= S_IDLE;
      out_port  <= manual_nxt;
      phase_cnt <= '0;
      phase_len <= '0;
      remaining <= '0;
    end else if (start_req) begin
      state     <= S_ON;
      out_port  <= 1'b1;
      phase_cnt <= '0;
      phase_len <= period_eff;
      remaining <= count_r;
    end else begin
      case (state)
        S_IDLE: begin
          out_port <= manual_nxt;
        end
        S_ON: begin
          if (phase_end) begin
            state     <= S_OFF;
            out_port  <= 1'b0;
            phase_cnt <= '0;
            phase_len <= period_eff;
          end else if (tick) begin
            phase_cnt <= phase_cnt + ONE;
          end
        end
        S_OFF: begin
          if (phase_end) begin
            phase_cnt <= '0;
            if (remaining == ONE) begin
              state    <= S_IDLE;
              out_port <= manual_nxt;
            end else begin
              // remaining == 0 marks an endless run and is never decremented
              if (remaining != '0) remaining <= remaining - ONE;
              state     <= S_ON;
              out_port  <= 1'b1;
              phase_len <= period_eff;
            end
          end else if (tick) begin
            phase_cnt <= phase_cnt + ONE;
          end
        end
        default: begin
          state    <= S_IDLE;
          out_port <= manual_nxt;
        end
      endcase
    end
  end

  always_comb begin
    readdata = '0;
    case (address)
      REG_CTRL: begin
        readdata[CTRL_MANUAL] = manual;
        readdata[CTRL_IRQ_EN] = irq_en;
      end
      REG_PERIOD: readdata[CNT_W-1:0] = period_r;
      REG_COUNT:  readdata[CNT_W-1:0] = count_r;
      default: begin
        readdata[ST_BUSY] = (state != S_IDLE);
        readdata[ST_DONE] = done;
        readdata[ST_OUT]  = out_port;
        readdata[ST_REM_LSB +: CNT_W] = remaining;
      end
    endcase
  end

endmodule

// File: tb/tb_alarm_led_blinker.sv
module tb_alarm_led_blinker;

  localparam int P  = 4;
  localparam int CW = 16;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [1:0]  address = 2'd0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic [31:0] writedata = 32'd0;
  logic [31:0] readdata;
  logic        alarm_trig = 1'b0;
  logic        out_port;
  logic        irq;

  always #5 clk = ~clk;

  alarm_led_blinker #(
    .PRESCALE(P),
    .CNT_W(CW)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .alarm_trig (alarm_trig),
    .out_port   (out_port),
    .irq        (irq)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Behavioural model: a run is described by whether it is active, which
  // half it is in, how many clock cycles are left in that half and how many
  // blinks remain.
  bit m_busy, m_on, m_done, m_manual, m_irqen, m_trig_prev;
  int m_left, m_blinks, m_period, m_count;

  logic        s_out, s_irq;
  logic [31:0] s_rd;

  typedef struct {
    logic        cs;
    logic        wn;
    logic [1:0]  a;
    logic [31:0] wd;
    logic        trig;
    logic        exp_out;
    logic        exp_irq;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t tbl[9];

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 40)
        $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic void model_reset();
    m_busy = 0; m_on = 0; m_done = 0; m_manual = 0; m_irqen = 0; m_trig_prev = 0;
    m_left = 0; m_blinks = 0; m_period = 0; m_count = 0;
  endfunction

  function automatic logic model_out();
    return m_busy ? m_on : m_manual;
  endfunction

  function automatic logic [31:0] model_rd(input logic [1:0] a);
    logic [31:0] r;
    logic [15:0] rem;
    r = 32'd0;
    rem = m_blinks[15:0];
    case (a)
      2'd0: r = {28'd0, m_irqen, m_manual, 2'b00};
      2'd1: r = 32'(m_period);
      2'd2: r = 32'(m_count);
      default: r = {rem, 13'd0, model_out(), m_done, m_busy};
    endcase
    return r;
  endfunction

  function automatic void model_step(input logic cs, input logic wn, input logic [1:0] a,
                                     input logic [31:0] wd, input logic trig);
    bit wr, cw, start, stop, dset;
    int plen;
    wr    = cs && !wn;
    cw    = wr && (a == 2'd0);
    start = (cw && wd[0]) || (trig && !m_trig_prev);
    stop  = cw && wd[1];
    dset  = 0;
    plen  = (m_period == 0) ? 1 : m_period;
    if (stop) begin
      m_busy = 0; m_blinks = 0;
    end else if (start) begin
      m_busy = 1; m_on = 1; m_left = plen * P; m_blinks = m_count;
    end else if (m_busy) begin
      m_left--;
      if (m_left == 0) begin
        if (m_on) begin
          m_on = 0; m_left = plen * P;
        end else if (m_blinks == 1) begin
          m_busy = 0; dset = 1;
        end else begin
          if (m_blinks != 0) m_blinks--;
          m_on = 1; m_left = plen * P;
        end
      end
    end
    if (dset) m_done = 1;
    else if (wr && a == 2'd3 && wd[1]) m_done = 0;
    if (cw) begin m_manual = wd[2]; m_irqen = wd[3]; end
    if (wr && a == 2'd1) m_period = int'(wd[15:0]);
    if (wr && a == 2'd2) m_count  = int'(wd[15:0]);
    m_trig_prev = trig;
  endfunction

  // One bus cycle: drive, sample mid-cycle against the model, advance model at the edge
  task automatic cycle(input logic cs, input logic wn, input logic [1:0] a,
                       input logic [31:0] wd, input logic trig);
    chipselect = cs; write_n = wn; address = a; writedata = wd; alarm_trig = trig;
    @(negedge clk);
    s_out = out_port; s_irq = irq; s_rd = readdata;
    check("out_port", {31'd0, s_out}, {31'd0, model_out()});
    check("irq", {31'd0, s_irq}, {31'd0, m_done & m_irqen});
    check("readdata", s_rd, model_rd(a));
    @(posedge clk);
    model_step(cs, wn, a, wd, trig);
    #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    cycle(1'b1, 1'b0, a, d, 1'b0);
  endtask

  task automatic rd(input logic [1:0] a);
    cycle(1'b1, 1'b1, a, 32'd0, 1'b0);
  endtask

  task automatic idle();
    cycle(1'b0, 1'b1, 2'd3, 32'd0, 1'b0);
  endtask

  initial begin
    logic exp_bit;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;

    // Reset reads and manual level
    tbl[0] = '{1'b1, 1'b1, 2'd0, 32'd0,   1'b0, 1'b0, 1'b0, 32'd0};
    tbl[1] = '{1'b1, 1'b1, 2'd1, 32'd0,   1'b0, 1'b0, 1'b0, 32'd0};
    tbl[2] = '{1'b1, 1'b1, 2'd2, 32'd0,   1'b0, 1'b0, 1'b0, 32'd0};
    tbl[3] = '{1'b1, 1'b1, 2'd3, 32'd0,   1'b0, 1'b0, 1'b0, 32'd0};
    tbl[4] = '{1'b1, 1'b0, 2'd0, 32'h4,   1'b0, 1'b0, 1'b0, 32'd0};
    tbl[5] = '{1'b1, 1'b1, 2'd3, 32'd0,   1'b0, 1'b1, 1'b0, 32'h4};
    tbl[6] = '{1'b1, 1'b1, 2'd0, 32'd0,   1'b0, 1'b1, 1'b0, 32'h4};
    tbl[7] = '{1'b1, 1'b0, 2'd0, 32'h0,   1'b0, 1'b1, 1'b0, 32'h4};
    tbl[8] = '{1'b1, 1'b1, 2'd3, 32'd0,   1'b0, 1'b0, 1'b0, 32'd0};
    for (int i = 0; i < 9; i++) begin
      cycle(tbl[i].cs, tbl[i].wn, tbl[i].a, tbl[i].wd, tbl[i].trig);
      check("tbl_out", {31'd0, s_out}, {31'd0, tbl[i].exp_out});
      check("tbl_irq", {31'd0, s_irq}, {31'd0, tbl[i].exp_irq});
      check("tbl_rd", s_rd, tbl[i].exp_rd);
    end

    // Finite run: 3 blinks of 8 on / 8 off, then done with irq
    wr(2'd1, 32'd2);
    wr(2'd2, 32'd3);
    wr(2'd0, 32'h9);
    for (int j = 0; j < 48; j++) begin
      idle();
      exp_bit = ((j / 8) % 2) == 0;
      check("run3_pattern", {31'd0, s_out}, {31'd0, exp_bit});
    end
    rd(2'd3);
    check("run3_status", {29'd0, s_rd[2:0]}, 32'h2);
    check("run3_irq", {31'd0, s_irq}, 32'd1);
    wr(2'd3, 32'h2);
    rd(2'd3);
    check("w1c_irq", {31'd0, s_irq}, 32'd0);
    check("w1c_status", {29'd0, s_rd[2:0]}, 32'h0);

    // Endless run from a one-cycle trigger pulse, then STOP
    wr(2'd2, 32'd0);
    wr(2'd1, 32'd1);
    cycle(1'b0, 1'b1, 2'd3, 32'd0, 1'b1);
    for (int j = 0; j < 24; j++) begin
      idle();
      exp_bit = ((j / 4) % 2) == 0;
      check("endless_pattern", {31'd0, s_out}, {31'd0, exp_bit});
    end
    wr(2'd0, 32'h2);
    rd(2'd3);
    check("stop_out", {31'd0, s_out}, 32'd0);
    check("stop_status", {30'd0, s_rd[1:0]}, 32'd0);

    // START and STOP in one write: STOP wins
    wr(2'd1, 32'd2);
    wr(2'd0, 32'h1);
    repeat (5) idle();
    wr(2'd0, 32'h3);
    rd(2'd3);
    check("startstop_busy", {31'd0, s_rd[0]}, 32'd0);
    repeat (3) idle();

    // Restart at cycle 10 of a 16-cycle ON phase
    wr(2'd1, 32'd4);
    wr(2'd2, 32'd2);
    wr(2'd0, 32'h1);
    repeat (10) idle();
    wr(2'd0, 32'h1);
    for (int k = 0; k < 18; k++) begin
      idle();
      if (k == 15) check("restart_on_end", {31'd0, s_out}, 32'd1);
      if (k == 16) check("restart_off", {31'd0, s_out}, 32'd0);
    end

    // Asynchronous reset in the middle of the OFF phase
    wr(2'd0, 32'h8);
    #2;
    reset_n = 1'b0;
    #1;
    check("async_rst_out", {31'd0, out_port}, 32'd0);
    check("async_rst_irq", {31'd0, irq}, 32'd0);
    check("async_rst_status", readdata, 32'd0);
    model_reset();
    @(posedge clk);
    #1;
    reset_n = 1'b1;

    // Trigger held high for 5 cycles starts exactly one run
    for (int t = 0; t < 5; t++) begin
      cycle(1'b0, 1'b1, 2'd3, 32'd0, 1'b1);
      exp_bit = (t != 0);
      check("trig_hold", {31'd0, s_out}, {31'd0, exp_bit});
    end
    idle();
    check("trig_single_run", {31'd0, s_out}, 32'd0);
    wr(2'd0, 32'h2);
    idle();

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      logic        cs, wn, tr;
      logic [1:0]  a;
      logic [31:0] wd;
      cs = ($urandom_range(0, 9) < 3);
      wn = ($urandom_range(0, 2) != 0);
      a  = 2'($urandom_range(0, 3));
      wd = $urandom;
      if (a == 2'd1 || a == 2'd2) wd[15:2] = 14'd0;
      if (a == 2'd0) begin
        wd[1] = ($urandom_range(0, 5) == 0);
        wd[0] = ($urandom_range(0, 2) == 0);
      end
      tr = ($urandom_range(0, 39) == 0);
      cycle(cs, wn, a, wd, tr);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
